state_dump_unit: RTL and testbench
==================================

STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC, register, memory and output words.
REQ-002 SHALL have parameter NUM_REGS, default 32, register-file entries dumped per frame (>=1).
REQ-003 SHALL have parameter MEM_WORDS, default 32, data-memory words dumped per frame (>=1).
REQ-004 SHALL have parameter DUMP_MEM, default 1, 1 = include the memory section, 0 = omit it.
REQ-005 SHALL have parameter CNT_W, default 16, width of the frame and drop counters.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port trig_i, input, 1, dump request, sampled on each rising edge.
REQ-009 SHALL have port pc_i, input, DATA_W, current CPU PC.
REQ-010 SHALL have port reg_addr_o, output, clog2(NUM_REGS), register-file read address.
REQ-011 SHALL have port reg_data_i, input, DATA_W, combinational register read data.
REQ-012 SHALL have port mem_addr_o, output, clog2(MEM_WORDS), data-memory word read address.
REQ-013 SHALL have port mem_data_i, input, DATA_W, combinational memory read data.
REQ-014 SHALL have port stall_o, output, 1, freezes the CPU while a frame is in progress.
REQ-015 SHALL have port out_valid_o, output, 1; out_ready_i, input, 1; out_data_o, output, DATA_W; out_tag_o, output, 2 (0 = PC header, 1 = register, 2 = memory); out_last_o, output, 1, final word of the frame.
REQ-016 SHALL have port frame_cnt_o, output, CNT_W, completed frames; drop_cnt_o, output, CNT_W, rejected triggers.

Function
REQ-017 SHALL implement FSM IDLE -> HDR -> REGS -> MEM (when DUMP_MEM=1) -> IDLE.
REQ-018 In IDLE, trig_i=1 at an edge SHALL capture pc_i into out_data_o, set out_tag_o=0, out_valid_o=1, stall_o=1, and enter HDR.
REQ-019 Frame length SHALL be 1+NUM_REGS+(DUMP_MEM?MEM_WORDS:0) words, sent in order: header, registers 0..NUM_REGS-1, memory words 0..MEM_WORDS-1.
REQ-020 A transfer SHALL occur on an edge where out_valid_o&out_ready_i; only then SHALL the output register load the next word.
REQ-021 The next word SHALL be loaded at the transfer edge from reg_data_i/mem_data_i at the address presented during that cycle; reg_addr_o/mem_addr_o SHALL equal the index of the next word to load.
REQ-022 While out_valid_o=1 and out_ready_i=0, out_data_o, out_tag_o and out_last_o SHALL hold stable.
REQ-023 out_last_o SHALL be 1 only with the final word; after its transfer, out_valid_o and stall_o SHALL be 0 in the next cycle, the FSM SHALL return to IDLE, and frame_cnt_o SHALL increment.
REQ-024 With out_ready_i held at 1, a frame SHALL take exactly frame-length cycles, with no bubbles between words.
REQ-025 trig_i=1 in any state other than IDLE SHALL increment drop_cnt_o and SHALL NOT affect the frame in progress.
REQ-026 trig_i=1 on the same edge as the final transfer SHALL count as dropped, with no back-to-back frame; the next accept requires IDLE.
REQ-027 frame_cnt_o SHALL wrap modulo 2^CNT_W; drop_cnt_o SHALL saturate at 2^CNT_W-1.
REQ-028 In IDLE, reg_addr_o and mem_addr_o SHALL be 0.
REQ-029 The index counters SHALL wrap from NUM_REGS-1 and MEM_WORDS-1 to 0 on a section change, with no out-of-range address driven.

Reset
REQ-030 rst_i=1 SHALL immediately force IDLE, out_valid_o=0, out_last_o=0, stall_o=0, out_data_o=0, out_tag_o=0, both address outputs 0, and both counters 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no further words and no frame_cnt_o increment; the first trig_i after release SHALL start a fresh frame from the header.

Verification (NUM_REGS=4, MEM_WORDS=2, DUMP_MEM=1, regs=10,11,12,13, mem=20,21)
REQ-032 Case 1: pc_i=0x40, trig_i pulse, out_ready_i=1 -> 7 consecutive words 0x40,10,11,12,13,20,21 with tags 0,1,1,1,1,2,2; last on word 21; stall_o high 7 cycles; frame_cnt_o=1.
REQ-033 Case 2: same as case 1, but out_ready_i low for 3 cycles while word 12 is presented -> word 12 held stable; sequence unchanged; frame takes 10 cycles.
REQ-034 Case 3: trig_i pulsed 3 times mid-frame plus once on the last-transfer edge -> drop_cnt_o=4; one frame output; FSM in IDLE afterwards.
REQ-035 Case 4: rst_i asserted during word 11 -> out_valid_o and stall_o drop without waiting for a clock edge; frame_cnt_o=0; a new trigger with pc_i=0x80 yields header 0x80.
REQ-036 Case 5: DUMP_MEM=0 -> 5-word frame; last on word 13; mem_addr_o stays 0.
REQ-037 Case 6: CNT_W=2, 5 dropped triggers -> drop_cnt_o=3; 5 frames -> frame_cnt_o=1.

Source files
------------

// File: rtl/state_dump_unit.sv
// state_dump_unit: on a trigger, freezes the CPU and streams one state frame
// (PC header, register file, optionally data memory) over a valid/ready port.
// Read addresses are driven from the index counters so the combinational
// register/memory read data is ready to load on the transfer edge.
module state_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 32,
  parameter int DUMP_MEM  = 1,
  parameter int CNT_W     = 16,
  localparam int RA_W     = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1,
  localparam int MA_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [RA_W-1:0]   reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [MA_W-1:0]   mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              stall_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        out_tag_o,
  output logic              out_last_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  // HDR/REGS: the next word to load comes from the register file.
  // MEM: the next word to load comes from data memory.
  // Once out_last_o is set there is nothing more to load; the next transfer
  // closes the frame regardless of the state name.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_REGS = 2'd2;
  localparam logic [1:0] S_MEM  = 2'd3;

  localparam logic [1:0] TAG_HDR = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam logic [RA_W-1:0] REG_LAST = RA_W'(NUM_REGS - 1);
  localparam logic [MA_W-1:0] MEM_LAST = MA_W'(MEM_WORDS - 1);
  localparam logic            MEM_EN   = (DUMP_MEM != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]      state;
  logic [RA_W-1:0] reg_idx;
  logic [MA_W-1:0] mem_idx;
  logic            xfer;

  assign xfer       = out_valid_o & out_ready_i;
  assign stall_o    = (state != S_IDLE);
  // Index counters wrap to 0 at every section end, so they already read 0 in IDLE.
  assign reg_addr_o = reg_idx;
  assign mem_addr_o = mem_idx;

  // Frame sequencer: accepts a trigger in IDLE and advances one word per transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      reg_idx     <= '0;
      mem_idx     <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= TAG_HDR;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig_i) begin
            out_data_o  <= pc_i;
            out_tag_o   <= TAG_HDR;
            out_valid_o <= 1'b1;
            out_last_o  <= 1'b0;
            state       <= S_HDR;
          end
        end
        default: begin
          if (xfer) begin
            if (out_last_o) begin
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
              state       <= S_IDLE;
            end else if (state != S_MEM) begin
              out_data_o <= reg_data_i;
              out_tag_o  <= TAG_REG;
              if (reg_idx == REG_LAST) begin
                reg_idx <= '0;
                if (MEM_EN) begin
                  state      <= S_MEM;
                  out_last_o <= 1'b0;
                end else begin
                  state      <= S_REGS;
                  out_last_o <= 1'b1;
                end
              end else begin
                reg_idx    <= reg_idx + RA_W'(1);
                state      <= S_REGS;
                out_last_o <= 1'b0;
              end
            end else begin
              out_data_o <= mem_data_i;
              out_tag_o  <= TAG_MEM;
              if (mem_idx == MEM_LAST) begin
                mem_idx    <= '0;
                out_last_o <= 1'b1;
              end else begin
                mem_idx    <= mem_idx + MA_W'(1);
                out_last_o <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // Completed frames wrap; triggers outside IDLE (including on the closing edge) saturate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (xfer && out_last_o)
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      if (trig_i && (state != S_IDLE))
        drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: a main instance (4 regs, 2 mem words) checked
// through a scoreboard, plus a no-memory instance and a 2-bit-counter instance.
module tb_state_dump_unit;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  t;
    logic        l;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          stall_at;
    int          stall_len;
    int          trig_mask;
    int          exp_cycles;
    int          exp_drops;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc = 32'h0;
  always #5 clk = ~clk;

  // main instance
  logic        trig = 1'b0, ready = 1'b1;
  logic [1:0]  raddr;
  logic [0:0]  maddr;
  logic [31:0] rdata, mdata, odata;
  logic        stall, ovalid, olast;
  logic [1:0]  otag;
  logic [15:0] fcnt, dcnt;
  assign rdata = 32'd10 + {30'd0, raddr};
  assign mdata = 32'd20 + {31'd0, maddr};

  state_dump_unit #(.DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .DUMP_MEM(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .pc_i(pc),
    .reg_addr_o(raddr), .reg_data_i(rdata), .mem_addr_o(maddr), .mem_data_i(mdata),
    .stall_o(stall), .out_valid_o(ovalid), .out_ready_i(ready), .out_data_o(odata),
    .out_tag_o(otag), .out_last_o(olast), .frame_cnt_o(fcnt), .drop_cnt_o(dcnt));

  // instance without the memory section
  logic        trig_nm = 1'b0, ready_nm = 1'b1;
  logic [1:0]  raddr_nm;
  logic [0:0]  maddr_nm;
  logic [31:0] rdata_nm, mdata_nm, odata_nm;
  logic        stall_nm, ovalid_nm, olast_nm;
  logic [1:0]  otag_nm;
  logic [15:0] fcnt_nm, dcnt_nm;
  assign rdata_nm = 32'd10 + {30'd0, raddr_nm};
  assign mdata_nm = 32'd20 + {31'd0, maddr_nm};

  state_dump_unit #(.DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .DUMP_MEM(0), .CNT_W(16)) dut_nm (
    .clk_i(clk), .rst_i(rst), .trig_i(trig_nm), .pc_i(pc),
    .reg_addr_o(raddr_nm), .reg_data_i(rdata_nm), .mem_addr_o(maddr_nm), .mem_data_i(mdata_nm),
    .stall_o(stall_nm), .out_valid_o(ovalid_nm), .out_ready_i(ready_nm), .out_data_o(odata_nm),
    .out_tag_o(otag_nm), .out_last_o(olast_nm), .frame_cnt_o(fcnt_nm), .drop_cnt_o(dcnt_nm));

  // instance with 2-bit counters
  logic        trig_c2 = 1'b0, ready_c2 = 1'b1;
  logic [1:0]  raddr_c2;
  logic [0:0]  maddr_c2;
  logic [31:0] rdata_c2, mdata_c2, odata_c2;
  logic        stall_c2, ovalid_c2, olast_c2;
  logic [1:0]  otag_c2;
  logic [1:0]  fcnt_c2, dcnt_c2;
  assign rdata_c2 = 32'd10 + {30'd0, raddr_c2};
  assign mdata_c2 = 32'd20 + {31'd0, maddr_c2};

  state_dump_unit #(.DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .DUMP_MEM(1), .CNT_W(2)) dut_c2 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig_c2), .pc_i(pc),
    .reg_addr_o(raddr_c2), .reg_data_i(rdata_c2), .mem_addr_o(maddr_c2), .mem_data_i(mdata_c2),
    .stall_o(stall_c2), .out_valid_o(ovalid_c2), .out_ready_i(ready_c2), .out_data_o(odata_c2),
    .out_tag_o(otag_c2), .out_last_o(olast_c2), .frame_cnt_o(fcnt_c2), .drop_cnt_o(dcnt_c2));

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] p);
    q.push_back('{p, 2'd0, 1'b0});
    for (int i = 0; i < 4; i++) q.push_back('{32'(10 + i), 2'd1, 1'b0});
    for (int j = 0; j < 2; j++) q.push_back('{32'(20 + j), 2'd2, (j == 1)});
  endtask

  // Scoreboard monitor: compares every transfer and checks hold stability.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_d = 32'h0;
  logic [1:0]  hold_t = 2'd0;
  logic        hold_l = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("hold_data", 64'(odata), 64'(hold_d));
        chk("hold_tag",  64'(otag),  64'(hold_t));
        chk("hold_last", 64'(olast), 64'(hold_l));
      end
      if (ovalid && ready) begin
        chk("sb_pending", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          chk("sb_data", 64'(odata), 64'(q[0].d));
          chk("sb_tag",  64'(otag),  64'(q[0].t));
          chk("sb_last", 64'(olast), 64'(q[0].l));
          q.pop_front();
        end
      end
      if (!stall) begin
        chk("idle_reg_addr", 64'(raddr), 64'(0));
        chk("idle_mem_addr", 64'(maddr), 64'(0));
      end
      hold_prev <= ovalid && !ready;
      hold_d    <= odata;
      hold_t    <= otag;
      hold_l    <= olast;
    end
  end

  // Drives one frame on the main instance; trig_mask bit c raises trig in frame cycle c.
  task automatic run_frame(input logic [31:0] p, input int stall_at, input int stall_len,
                           input int trig_mask, output int cycles);
    int k, held;
    @(negedge clk);
    pc   = p;
    trig = 1'b1;
    push_frame(p);
    @(posedge clk); #1;
    trig   = 1'b0;
    cycles = 0;
    k      = 0;
    held   = 0;
    for (int c = 0; c < 200; c++) begin
      if (!stall) break;
      cycles++;
      trig = trig_mask[c % 32] && (c < 32);
      if (k == stall_at && held < stall_len) begin
        ready = 1'b0;
        held++;
      end else begin
        ready = 1'b1;
      end
      @(negedge clk);
      if (ovalid && ready) k++;
      @(posedge clk); #1;
    end
    trig  = 1'b0;
    ready = 1'b1;
  endtask

  vec_t vecs[5];
  int   cyc;
  int   exp_frames;
  int   exp_drops;

  initial begin
    vecs[0] = '{32'h40, -1, 0, 0,    7,  0};
    vecs[1] = '{32'h44,  3, 3, 0,    10, 0};
    vecs[2] = '{32'h48, -1, 0, 32'h4E, 7, 4};
    vecs[3] = '{32'h4C,  0, 2, 0,    9,  0};
    vecs[4] = '{32'h50,  6, 1, 0,    8,  0};

    // reset state
    #12;
    chk("rst_valid", 64'(ovalid), 64'(0));
    chk("rst_last",  64'(olast),  64'(0));
    chk("rst_stall", 64'(stall),  64'(0));
    chk("rst_data",  64'(odata),  64'(0));
    chk("rst_tag",   64'(otag),   64'(0));
    chk("rst_raddr", 64'(raddr),  64'(0));
    chk("rst_maddr", 64'(maddr),  64'(0));
    chk("rst_fcnt",  64'(fcnt),   64'(0));
    chk("rst_dcnt",  64'(dcnt),   64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven frames on the main instance
    exp_frames = 0;
    exp_drops  = 0;
    foreach (vecs[i]) begin
      run_frame(vecs[i].pc, vecs[i].stall_at, vecs[i].stall_len, vecs[i].trig_mask, cyc);
      exp_frames++;
      exp_drops += vecs[i].exp_drops;
      chk("frame_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
      chk("frame_cnt",    64'(fcnt), 64'(exp_frames));
      chk("drop_cnt",     64'(dcnt), 64'(exp_drops));
      chk("sb_drained",   64'(q.size()), 64'(0));
      @(posedge clk); #1;
      chk("no_back_to_back", 64'(ovalid), 64'(0));
      chk("idle_stall",      64'(stall),  64'(0));
    end

    // reset in the middle of a frame
    @(negedge clk);
    pc   = 32'h60;
    trig = 1'b1;
    push_frame(32'h60);
    @(posedge clk); #1;
    trig = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_word", 64'(odata), 64'(11));
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(ovalid), 64'(0));
    chk("async_stall", 64'(stall),  64'(0));
    chk("async_data",  64'(odata),  64'(0));
    chk("async_fcnt",  64'(fcnt),   64'(0));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(32'h80, -1, 0, 0, cyc);
    chk("post_rst_cycles", 64'(cyc),  64'(7));
    chk("post_rst_fcnt",   64'(fcnt), 64'(1));
    chk("post_rst_sb",     64'(q.size()), 64'(0));

    // no memory section: 5-word frame
    @(negedge clk);
    pc      = 32'h90;
    trig_nm = 1'b1;
    @(negedge clk);
    trig_nm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("nm_valid", 64'(ovalid_nm), 64'(1));
      chk("nm_data",  64'(odata_nm), (i == 0) ? 64'h90 : 64'(9 + i));
      chk("nm_tag",   64'(otag_nm),  (i == 0) ? 64'(0) : 64'(1));
      chk("nm_last",  64'(olast_nm), 64'(i == 4));
      chk("nm_maddr", 64'(maddr_nm), 64'(0));
      @(negedge clk);
    end
    chk("nm_end_valid", 64'(ovalid_nm), 64'(0));
    chk("nm_end_stall", 64'(stall_nm),  64'(0));
    chk("nm_fcnt",      64'(fcnt_nm),   64'(1));
    chk("nm_dcnt",      64'(dcnt_nm),   64'(0));
    chk("nm_raddr",     64'(raddr_nm),  64'(0));

    // 2-bit counters: drop saturates, frame wraps
    for (int f = 0; f < 5; f++) begin
      @(negedge clk);
      trig_c2 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      trig_c2 = 1'b0;
      repeat (8) @(negedge clk);
      chk("c2_dcnt", 64'(dcnt_c2), 64'((f + 1 > 3) ? 3 : f + 1));
      chk("c2_fcnt", 64'(fcnt_c2), 64'((f + 1) % 4));
    end
    chk("c2_idle_valid", 64'(ovalid_c2), 64'(0));
    chk("c2_idle_stall", 64'(stall_c2),  64'(0));
    chk("c2_final_data", 64'(odata_c2),  64'(21));
    chk("c2_final_tag",  64'(otag_c2),   64'(2));
    chk("c2_final_last", 64'(olast_c2),  64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
